// File: rtl/smc_seq_ctrl.sv
// smc_seq_ctrl: serial operand collector and sequencer for the sort/compute datapath.
// Optional macro RES_PIPE_EN adds a second result register stage (latency 3).
module smc_seq_ctrl #(
    parameter int IN_W   = 4,
    parameter int OUT_W  = 10,
    parameter int NUM_OP = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  in_data,
    input  logic [2:0]       in_opt,
    input  logic             in_equ,
    output logic             busy,
    output logic             out_valid,
    output logic [OUT_W-1:0] out_n,
    output logic             err,
    output logic [IN_W-1:0]  dp_in_n0,
    output logic [IN_W-1:0]  dp_in_n1,
    output logic [IN_W-1:0]  dp_in_n2,
    output logic [IN_W-1:0]  dp_in_n3,
    output logic [IN_W-1:0]  dp_in_n4,
    output logic [IN_W-1:0]  dp_in_n5,
    output logic [2:0]       dp_opt,
    output logic             dp_equ,
    input  logic [OUT_W-1:0] dp_out_n
);

`ifdef RES_PIPE_EN
    typedef enum logic [2:0] {IDLE, LOAD, CALC, CALC2, OUT} state_t;
`else
    typedef enum logic [2:0] {IDLE, LOAD, CALC, OUT} state_t;
`endif

    localparam logic [2:0] LAST = 3'(NUM_OP - 1);

    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [2:0]        slot;
    logic              cap, first, abort;
    logic [IN_W-1:0]   ops_q [NUM_OP];
    logic [2:0]        opt_q;
    logic              equ_q;
    logic              err_q;
    logic [OUT_W-1:0]  res_q;
    logic [OUT_W-1:0]  res_out;

    // Next state, capture strobes and abort detection.
    // OUT accepts a new first nibble so back-to-back packets lose nothing.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cap     = 1'b0;
        first   = 1'b0;
        abort   = 1'b0;
        unique case (state_q)
            IDLE, OUT: begin
                if (in_valid) begin
                    cap     = 1'b1;
                    first   = 1'b1;
                    cnt_d   = 3'd1;
                    state_d = LOAD;
                end else begin
                    cnt_d   = 3'd0;
                    state_d = IDLE;
                end
            end
            LOAD: begin
                if (in_valid) begin
                    cap = 1'b1;
                    if (cnt_q == LAST) begin
                        cnt_d   = 3'd0;
                        state_d = CALC;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end else begin
                    abort   = 1'b1;
                    cnt_d   = 3'd0;
                    state_d = IDLE;
                end
            end
`ifdef RES_PIPE_EN
            CALC:  state_d = CALC2;
            CALC2: state_d = OUT;
`else
            CALC:  state_d = OUT;
`endif
            default: state_d = IDLE;
        endcase
    end

    assign slot = first ? 3'd0 : cnt_q;

    // State, counter and error pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= abort;
        end
    end

    // Operand and opt/equ capture; regs only move on accepted nibbles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_OP; i++) ops_q[i] <= '0;
            opt_q <= 3'd0;
            equ_q <= 1'b0;
        end else if (cap) begin
            ops_q[slot] <= in_data;
            if (first) begin
                opt_q <= in_opt;
                equ_q <= in_equ;
            end
        end
    end

    // Result capture at the end of CALC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) res_q <= '0;
        else if (state_q == CALC) res_q <= dp_out_n;
    end

`ifdef RES_PIPE_EN
    logic [OUT_W-1:0] res2_q;

    // Second result stage for a pipelined or timing-critical datapath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) res2_q <= '0;
        else if (state_q == CALC2) res2_q <= res_q;
    end

    assign res_out = res2_q;
`else
    assign res_out = res_q;
`endif

    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q == OUT);
    assign out_n     = out_valid ? res_out : '0;
    assign err       = err_q;

    assign dp_in_n0 = ops_q[0];
    assign dp_in_n1 = ops_q[1];
    assign dp_in_n2 = ops_q[2];
    assign dp_in_n3 = ops_q[3];
    assign dp_in_n4 = ops_q[4];
    assign dp_in_n5 = ops_q[5];
    assign dp_opt   = opt_q;
    assign dp_equ   = equ_q;

endmodule

// File: tb/tb_smc_seq_ctrl.sv
// tb_smc_seq_ctrl: directed bench for smc_seq_ctrl with a stub datapath.
// Honours RES_PIPE_EN for the expected result latency.
module tb_smc_seq_ctrl;

`ifdef RES_PIPE_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [3:0] in_data = 4'd0;
    logic [2:0] in_opt = 3'd0;
    logic       in_equ = 1'b0;
    logic       busy, out_valid, err;
    logic [9:0] out_n;
    logic [3:0] dp_in_n0, dp_in_n1, dp_in_n2;
    logic [3:0] dp_in_n3, dp_in_n4, dp_in_n5;
    logic [2:0] dp_opt;
    logic       dp_equ;
    logic [9:0] dp_out_n;

    int n_pass = 0;
    int n_total = 0;

    smc_seq_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_data(in_data),
        .in_opt(in_opt), .in_equ(in_equ),
        .busy(busy), .out_valid(out_valid),
        .out_n(out_n), .err(err),
        .dp_in_n0(dp_in_n0), .dp_in_n1(dp_in_n1),
        .dp_in_n2(dp_in_n2), .dp_in_n3(dp_in_n3),
        .dp_in_n4(dp_in_n4), .dp_in_n5(dp_in_n5),
        .dp_opt(dp_opt), .dp_equ(dp_equ),
        .dp_out_n(dp_out_n)
    );

    always #5 clk = ~clk;

    // Stub datapath: equ=0 -> n4*n5+n0, equ=1 -> n5*(n1-n0)-n0,
    // plus opt*128 so a wrongly latched opt shows in the result.
    function automatic logic [9:0] dp_model(
        input logic [3:0] a0, input logic [3:0] a1,
        input logic [3:0] a4, input logic [3:0] a5,
        input logic [2:0] o, input logic e);
        int r;
        if (e) r = int'(a5) * (int'(a1) - int'(a0)) - int'(a0);
        else   r = int'(a4) * int'(a5) + int'(a0);
        r = r + int'(o) * 128;
        return r[9:0];
    endfunction

    assign dp_out_n = dp_model(dp_in_n0, dp_in_n1, dp_in_n4,
                               dp_in_n5, dp_opt, dp_equ);

    task automatic chk(input string tag, input int got, input int exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        in_valid = 1'b0;
        in_data  = 4'hf;
        in_opt   = 3'b111;
        in_equ   = 1'b1;
    endtask

    // Drives cnt nibbles; opt/equ are inverted after the first cycle.
    task automatic send(input string tag, input logic [23:0] nib,
                        input logic [2:0] opt, input logic equ,
                        input int cnt);
        for (int i = 0; i < cnt; i++) begin
            in_valid = 1'b1;
            in_data  = nib[i*4 +: 4];
            in_opt   = (i == 0) ? opt : ~opt;
            in_equ   = (i == 0) ? equ : ~equ;
            if (i > 0) chk({tag, "_busy_load"}, busy, 1);
            if (i > 0) chk({tag, "_err_load"}, err, 0);
            tick();
        end
    endtask

    // Called right after the last operand edge; returns in the OUT cycle.
    task automatic wait_result(input string tag, input int exp);
        for (int j = 0; j < LAT - 1; j++) begin
            chk({tag, "_busy_calc"}, busy, 1);
            chk({tag, "_ov_calc"}, out_valid, 0);
            chk({tag, "_outn_calc"}, out_n, 0);
            tick();
        end
        chk({tag, "_ov"}, out_valid, 1);
        chk({tag, "_outn"}, out_n, exp);
        chk({tag, "_busy_out"}, busy, 1);
        chk({tag, "_err_out"}, err, 0);
    endtask

    task automatic after_out(input string tag);
        chk({tag, "_ov_after"}, out_valid, 0);
        chk({tag, "_outn_after"}, out_n, 0);
        chk({tag, "_busy_after"}, busy, 0);
    endtask

    initial begin
        idle_in();
        tick();
        tick();
        chk("rst_ov", out_valid, 0);
        chk("rst_outn", out_n, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_dp_n0", dp_in_n0, 0);
        chk("rst_dp_opt", dp_opt, 0);
        chk("rst_dp_equ", dp_equ, 0);
        rst_n = 1'b1;
        tick();

        // T1: 1..6, opt=0, equ=0 -> 4*... stub gives 5*6+1 = 31
        chk("t1_busy_first", busy, 0);
        send("t1", {4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1}, 3'd0, 1'b0, 6);
        idle_in();
        wait_result("t1", 31);
        chk("t1_dp_n0", dp_in_n0, 1);
        chk("t1_dp_n3", dp_in_n3, 4);
        chk("t1_dp_n5", dp_in_n5, 6);
        chk("t1_dp_opt", dp_opt, 0);
        tick();
        after_out("t1");
        tick();

        // T2: same nibbles, equ=1 -> 6*(2-1)-1 = 5
        send("t2", {4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1}, 3'd0, 1'b1, 6);
        idle_in();
        wait_result("t2", 5);
        chk("t2_dp_equ", dp_equ, 1);
        tick();
        after_out("t2");
        chk("t2_err", err, 0);
        tick();

        // T3: short packet of 3 nibbles -> err next cycle, no result
        send("t3", {4'd0, 4'd0, 4'd0, 4'd9, 4'd8, 4'd7}, 3'd2, 1'b0, 3);
        idle_in();
        chk("t3_busy_gap", busy, 1);
        tick();
        chk("t3_err", err, 1);
        chk("t3_busy", busy, 0);
        chk("t3_ov", out_valid, 0);
        tick();
        chk("t3_err_clr", err, 0);
        for (int j = 0; j < LAT + 1; j++) begin
            chk("t3_no_ov", out_valid, 0);
            tick();
        end
        // full packet 6,5,4,3,2,1 -> 2*1+6 = 8
        send("t3b", {4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6}, 3'd0, 1'b0, 6);
        idle_in();
        wait_result("t3b", 8);
        tick();
        after_out("t3b");
        tick();

        // T4: A = 2,3,1,4,5,6 opt=3 equ=0 -> 32+384 = 416
        //     B = 1,3,4,2,2,7 opt=1 equ=1 -> 13+128 = 141, starts in OUT
        send("t4a", {4'd6, 4'd5, 4'd4, 4'd1, 4'd3, 4'd2}, 3'd3, 1'b0, 6);
        idle_in();
        wait_result("t4a", 416);
        send("t4b", {4'd7, 4'd2, 4'd2, 4'd4, 4'd3, 4'd1}, 3'd1, 1'b1, 6);
        idle_in();
        wait_result("t4b", 141);
        chk("t4b_dp_n2", dp_in_n2, 4);
        chk("t4b_dp_opt", dp_opt, 1);
        tick();
        after_out("t4b");
        tick();

        // T5: reset asserted while slot 4 is presented
        send("t5", {4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1}, 3'd5, 1'b1, 4);
        in_valid = 1'b1;
        in_data  = 4'd5;
        #1;
        rst_n = 1'b0;
        #1;
        chk("t5_busy", busy, 0);
        chk("t5_ov", out_valid, 0);
        chk("t5_outn", out_n, 0);
        chk("t5_dp_n0", dp_in_n0, 0);
        chk("t5_dp_opt", dp_opt, 0);
        chk("t5_dp_equ", dp_equ, 0);
        tick();
        in_data = 4'd6;
        tick();
        rst_n = 1'b1;
        idle_in();
        for (int j = 0; j < LAT + 3; j++) begin
            chk("t5_no_ov", out_valid, 0);
            chk("t5_no_busy", busy, 0);
            chk("t5_no_err", err, 0);
            tick();
        end

        // Recovery with T1 stimulus
        send("t5r", {4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1}, 3'd0, 1'b0, 6);
        idle_in();
        wait_result("t5r", 31);
        tick();
        after_out("t5r");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
